// File: rtl/dma_out_packer.sv
// Packs FWFT FIFO bytes little-endian into 32-bit AXI4-Stream beats; tkeep under DMA_OUT_PACKER_TKEEP_EN.
// Latency: tvalid rises the cycle after the pop that completes a beat; one full beat every 5 cycles.
// Backpressure: no pops while a beat waits for tready, so the FIFO's full flag is the only upstream stall.
module dma_out_packer #(
    parameter int LEN_WIDTH = 24,
    parameter int OUT_BYTES = 4
) (
    input  logic                   clk_i,
    input  logic                   a_rstn_i,
    input  logic                   fifo_empty_i,
    input  logic [7:0]             fifo_rdata_i,
    output logic                   fifo_rd_en_o,
    input  logic                   start_i,
    input  logic [LEN_WIDTH-1:0]   frame_len_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [8*OUT_BYTES-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
`ifdef DMA_OUT_PACKER_TKEEP_EN
    output logic [OUT_BYTES-1:0]   m_axis_tkeep,
`endif
    output logic                   m_axis_tlast
);
    localparam int IDX_W = $clog2(OUT_BYTES);
    localparam int DAT_W = 8 * OUT_BYTES;

    typedef enum logic [1:0] {IDLE, PACK, SEND} state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DAT_W-1:0]     data_q, data_d;
    logic                 last_q, last_d;
    logic                 done_q, done_d;
    logic                 pop;
`ifdef DMA_OUT_PACKER_TKEEP_EN
    logic [OUT_BYTES-1:0] keep_q, keep_d;
`endif

    assign pop = (state_q == PACK) && !fifo_empty_i;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        data_d      = data_q;
        last_d      = last_q;
        done_d      = 1'b0;
`ifdef DMA_OUT_PACKER_TKEEP_EN
        keep_d      = keep_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (frame_len_i != '0) begin
                        remaining_d = frame_len_i;
                        idx_d       = '0;
                        data_d      = '0;
                        last_d      = 1'b0;
                        state_d     = PACK;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            PACK: begin
                if (pop) begin
                    data_d[8*idx_q +: 8] = fifo_rdata_i;
                    idx_d       = idx_q + 1'b1;
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (idx_q == IDX_W'(OUT_BYTES - 1) || remaining_q == LEN_WIDTH'(1)) begin
                        state_d = SEND;
                        last_d  = (remaining_q == LEN_WIDTH'(1));
`ifdef DMA_OUT_PACKER_TKEEP_EN
                        // Lanes up to and including the one just written are valid.
                        for (int l = 0; l < OUT_BYTES; l++) begin
                            keep_d[l] = (IDX_W'(l) <= idx_q);
                        end
`endif
                    end
                end
            end
            SEND: begin
                if (m_axis_tready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = '0;
                        data_d  = '0;
                        state_d = PACK;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge a_rstn_i) begin
        if (!a_rstn_i) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef DMA_OUT_PACKER_TKEEP_EN
            keep_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            last_q      <= last_d;
            done_q      <= done_d;
`ifdef DMA_OUT_PACKER_TKEEP_EN
            keep_q      <= keep_d;
`endif
        end
    end

    assign fifo_rd_en_o  = pop;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign m_axis_tvalid = (state_q == SEND);
    assign m_axis_tdata  = data_q;
    assign m_axis_tlast  = last_q;
`ifdef DMA_OUT_PACKER_TKEEP_EN
    assign m_axis_tkeep  = keep_q;
`endif

endmodule

// File: tb/tb_dma_out_packer.sv
// Bench for dma_out_packer: a FIFO queue feeds random or sequential frames; expected beats
// are computed per frame by chunking the byte list into little-endian words.
module tb_dma_out_packer;
    logic        clk_i = 1'b0;
    logic        a_rstn_i;
    logic        fifo_empty_i;
    logic [7:0]  fifo_rdata_i;
    logic        fifo_rd_en_o;
    logic        start_i;
    logic [23:0] frame_len_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [3:0]  m_axis_tkeep;

    always #5 clk_i = ~clk_i;

    dma_out_packer #(.LEN_WIDTH(24), .OUT_BYTES(4)) dut (
        .clk_i         (clk_i),
        .a_rstn_i      (a_rstn_i),
        .fifo_empty_i  (fifo_empty_i),
        .fifo_rdata_i  (fifo_rdata_i),
        .fifo_rd_en_o  (fifo_rd_en_o),
        .start_i       (start_i),
        .frame_len_i   (frame_len_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
`ifdef DMA_OUT_PACKER_TKEEP_EN
        .m_axis_tkeep  (m_axis_tkeep),
`endif
        .m_axis_tlast  (m_axis_tlast)
    );

`ifndef DMA_OUT_PACKER_TKEEP_EN
    assign m_axis_tkeep = 4'hf;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] fifo_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_tvalid"}, {31'd0, m_axis_tvalid}, 32'd0);
        chk({nm, "_tdata"},  m_axis_tdata, 32'd0);
        chk({nm, "_tlast"},  {31'd0, m_axis_tlast}, 32'd0);
        chk({nm, "_busy"},   {31'd0, busy_o}, 32'd0);
        chk({nm, "_done"},   {31'd0, done_o}, 32'd0);
        chk({nm, "_rd_en"},  {31'd0, fifo_rd_en_o}, 32'd0);
    endtask

    // One frame from start to done pulse, checked every cycle against the chunked beat list.
    task automatic run_frame(input int len, input bit seq, input int gap_pct, input int stall_pct,
                             input int hold, input int gap_at, input int gap_len, input int junk_pct,
                             output int hs_cyc, output logic [31:0] first_dat,
                             output logic [31:0] last_dat, output logic [3:0] first_keep,
                             output logic [3:0] last_keep);
        logic [31:0] exp_d[$];
        logic        exp_l[$];
        logic [3:0]  exp_k[$];
        int nb, pops, tv_cnt, gap_done, nbeats;
        bit final_seen, gap, exp_done;
        logic prev_v, prev_r, prev_l;
        logic [31:0] prev_d, w;
        int n;

        fifo_q.delete();
        for (int i = 0; i < len; i++) fifo_q.push_back(seq ? 8'(i + 1) : 8'($urandom));
        nb = (len + 3) / 4;
        for (int b = 0; b < nb; b++) begin
            w = 32'd0;
            n = 0;
            for (int j = 0; j < 4; j++) begin
                if (4 * b + j < len) begin
                    w[8*j +: 8] = fifo_q[4*b+j];
                    n++;
                end
            end
            exp_d.push_back(w);
            exp_l.push_back(b == nb - 1);
            exp_k.push_back(4'((1 << n) - 1));
        end

        pops = 0; tv_cnt = 0; gap_done = 0; nbeats = 0;
        final_seen = 0; hs_cyc = -1;
        first_dat = '0; last_dat = '0; first_keep = '0; last_keep = '0;
        prev_v = 0; prev_r = 0; prev_l = 0; prev_d = '0;

        for (int cyc = 0; ; cyc++) begin
            @(negedge clk_i);
            if (cyc > 3000) begin
                n_vec++;
                n_err++;
                $display("FAIL timeout: frame len %0d not done after %0d cycles", len, cyc);
                break;
            end
            start_i       = (cyc == 0) || (!final_seen && $urandom_range(99) < junk_pct);
            frame_len_i   = (cyc == 0) ? 24'(len) : 24'($urandom_range(1, 100));
            m_axis_tready = (tv_cnt >= hold) && ($urandom_range(99) >= stall_pct);
            gap = ($urandom_range(99) < gap_pct);
            if (pops == gap_at && gap_done < gap_len) begin
                gap = 1;
                gap_done++;
            end
            fifo_empty_i = gap || (fifo_q.size() == 0);
            fifo_rdata_i = fifo_empty_i ? 8'($urandom) : fifo_q[0];
            #1;
            exp_done = final_seen && (cyc == hs_cyc + 1);
            chk("done", {31'd0, done_o}, {31'd0, exp_done});
            if (cyc >= 1) chk("busy", {31'd0, busy_o}, {31'd0, !exp_done});
            chk("pop_legal", {31'd0, fifo_rd_en_o && (m_axis_tvalid || fifo_empty_i)}, 32'd0);
            if (prev_v && !prev_r) begin
                chk("hold_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
                chk("hold_tdata", m_axis_tdata, prev_d);
                chk("hold_tlast", {31'd0, m_axis_tlast}, {31'd0, prev_l});
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_d.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra_beat: got 0x%0h, want no beat", m_axis_tdata);
                end else begin
                    chk("beat_tdata", m_axis_tdata, exp_d[0]);
                    chk("beat_tlast", {31'd0, m_axis_tlast}, {31'd0, exp_l[0]});
`ifdef DMA_OUT_PACKER_TKEEP_EN
                    chk("beat_tkeep", {28'd0, m_axis_tkeep}, {28'd0, exp_k[0]});
`endif
                    if (nbeats == 0) begin
                        first_dat  = m_axis_tdata;
                        first_keep = m_axis_tkeep;
                    end
                    last_dat  = m_axis_tdata;
                    last_keep = m_axis_tkeep;
                    nbeats++;
                    if (exp_l[0]) begin
                        final_seen = 1;
                        hs_cyc     = cyc;
                    end
                    void'(exp_d.pop_front());
                    void'(exp_l.pop_front());
                    void'(exp_k.pop_front());
                end
            end
            if (m_axis_tvalid) tv_cnt++;
            if (fifo_rd_en_o) begin
                pops++;
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            end
            prev_v = m_axis_tvalid;
            prev_r = m_axis_tready;
            prev_d = m_axis_tdata;
            prev_l = m_axis_tlast;
            if (exp_done) begin
                chk("pop_count", pops, len);
                chk("beats_left", exp_d.size(), 0);
                break;
            end
        end
        start_i = 1'b0;
    endtask

    initial begin
        int hs;
        logic [31:0] fd, ld;
        logic [3:0] fk, lk;
        int p;

        a_rstn_i = 1'b0;
        start_i = 1'b0;
        frame_len_i = '0;
        fifo_empty_i = 1'b1;
        fifo_rdata_i = '0;
        m_axis_tready = 1'b0;
        #1;
        chk_idle_outputs("reset");
        repeat (3) @(negedge clk_i);
        a_rstn_i = 1'b1;
        @(negedge clk_i);

        // Length 8, sequential bytes, spurious starts while busy must be ignored.
        run_frame(8, 1, 0, 0, 0, -1, 0, 50, hs, fd, ld, fk, lk);
        chk("len8_hs_cycle", hs, 10);
        chk("len8_beat1", fd, 32'h04030201);
        chk("len8_beat2", ld, 32'h08070605);

        run_frame(6, 1, 0, 0, 0, -1, 0, 0, hs, fd, ld, fk, lk);
        chk("len6_hs_cycle", hs, 8);
        chk("len6_beat2", ld, 32'h00000605);
`ifdef DMA_OUT_PACKER_TKEEP_EN
        chk("len6_keep1", {28'd0, fk}, 32'hf);
        chk("len6_keep2", {28'd0, lk}, 32'h3);
`endif

        // tready held low for 10 cycles after tvalid rises.
        run_frame(4, 1, 0, 0, 10, -1, 0, 0, hs, fd, ld, fk, lk);
        chk("len4_stall_hs_cycle", hs, 15);
        chk("len4_stall_beat", fd, 32'h04030201);

        // FIFO empty for 3 cycles between bytes 2 and 3.
        run_frame(5, 1, 0, 0, 0, 2, 3, 0, hs, fd, ld, fk, lk);
        chk("len5_gap_hs_cycle", hs, 10);
        chk("len5_beat1", fd, 32'h04030201);
        chk("len5_beat2", ld, 32'h00000005);

        // Zero-length start: done next cycle, no pops, no beat.
        fifo_q.delete();
        fifo_q.push_back(8'h5a);
        @(negedge clk_i);
        start_i = 1'b1;
        frame_len_i = '0;
        fifo_empty_i = 1'b0;
        fifo_rdata_i = fifo_q[0];
        m_axis_tready = 1'b1;
        #1;
        chk("len0_done_c0", {31'd0, done_o}, 32'd0);
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        chk("len0_done_c1", {31'd0, done_o}, 32'd1);
        chk("len0_busy_c1", {31'd0, busy_o}, 32'd0);
        chk("len0_rd_en_c1", {31'd0, fifo_rd_en_o}, 32'd0);
        chk("len0_tvalid_c1", {31'd0, m_axis_tvalid}, 32'd0);
        @(negedge clk_i);
        #1;
        chk("len0_done_c2", {31'd0, done_o}, 32'd0);

        // Reset after two pops of a length-8 frame.
        fifo_q.delete();
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'(i + 1));
        p = 0;
        for (int c = 0; c < 20 && p < 2; c++) begin
            @(negedge clk_i);
            start_i = (c == 0);
            frame_len_i = 24'd8;
            fifo_empty_i = 1'b0;
            fifo_rdata_i = fifo_q[0];
            #1;
            if (fifo_rd_en_o) begin
                p++;
                void'(fifo_q.pop_front());
            end
        end
        chk("rst_pops_before", p, 2);
        @(negedge clk_i);
        start_i = 1'b0;
        a_rstn_i = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        @(negedge clk_i);
        a_rstn_i = 1'b1;
        run_frame(4, 1, 0, 0, 0, -1, 0, 0, hs, fd, ld, fk, lk);
        chk("post_rst_hs_cycle", hs, 5);
        chk("post_rst_beat", fd, 32'h04030201);

        // Randomized frames with FIFO gaps, sink stalls and ignored starts.
        for (int f = 0; f < 40; f++) begin
            run_frame($urandom_range(1, 40), 0, 20, 30, 0, -1, 0, 20, hs, fd, ld, fk, lk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dma_out_packer.md
# dma_out_packer

Downstream stage of the 8-bit DMA output FIFO in the hardware-accelerator datapath. It pops bytes from the FIFO's first-word-fall-through (FWFT) read port and packs them little-endian into 32-bit AXI4-Stream beats for the DMA write channel. Frame length is programmable in bytes, and `tlast` marks the final beat. Bytes are popped only while the stream is not stalled, so the FIFO's programmable-full flag remains the only backpressure seen by the accelerator.

## Interface
Parameters:
- `LEN_WIDTH`, 24, width of the frame byte count.
- `OUT_BYTES`, 4, bytes per output beat. This value is fixed at 4; any other value is unsupported.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`  in  1  datapath clock, shared with the DMA output FIFO.
- `a_rstn_i`  in  1  asynchronous active-low reset.
- `fifo_empty_i`  in  1  FIFO empty; when low, `fifo_rdata_i` holds a valid byte (FWFT).
- `fifo_rdata_i`  in  8  FIFO head byte.
- `fifo_rd_en_o`  out  1  pop strobe (combinational).
- `start_i`  in  1  single-cycle frame start.
- `frame_len_i`  in  LEN_WIDTH  frame length in bytes, sampled on `start_i`.
- `busy_o`  out  1  frame in progress.
- `done_o`  out  1  single-cycle pulse at frame end.
- `m_axis_tdata`  out  32  packed beat.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  sink ready.
- `m_axis_tlast`  out  1  final beat of frame.
- `m_axis_tkeep`  out  4  valid byte lanes. Present only with `DMA_OUT_PACKER_TKEEP_EN`.

## Operation
- FSM states are IDLE, PACK and SEND. Reset state is IDLE.
- IDLE:
  - `start_i` with `frame_len_i != 0` latches `remaining = frame_len_i`, clears the lane index and the data register, and moves to PACK.
  - `start_i` with length 0 raises `done_o` for one cycle next cycle and stays in IDLE.
- PACK:
  - `fifo_rd_en_o = (state == PACK) && !fifo_empty_i`.
  - On each pop, `fifo_rdata_i` is written to lane `idx` (bits `8*idx+7:8*idx`).
  - `idx` increments.
  - `remaining` decrements.
  - If `idx == 3` or `remaining == 1` at the pop, the FSM moves to SEND. `m_axis_tlast` is set iff `remaining == 1`.
- SEND:
  - `m_axis_tvalid` is 1.
  - `m_axis_tdata`, `tlast` and `tkeep` are held stable until `m_axis_tvalid && m_axis_tready`.
  - No pops occur in SEND.
  - On handshake:
    - If `tlast` is set: go to IDLE and pulse `done_o`.
    - Otherwise: clear `idx` and data, and return to PACK.
- `busy_o = (state != IDLE)`.
- `start_i` while busy is ignored. It does not re-latch the length.
- Unused lanes of a partial final beat are 0.
- `remaining` cannot underflow: the FSM leaves PACK on the last byte.
- FIFO empty in PACK stalls the packer indefinitely with no timeout. Bytes already packed are retained.
- Reset mid-frame:
  - All state returns to IDLE and all registered outputs go to 0.
  - Partially packed bytes are discarded.
  - The FIFO is not flushed by this block.

## Timing
- Reset values: `m_axis_tvalid`, `tlast`, `tdata`, `tkeep`, `busy_o` and `done_o` are all 0.
- `fifo_rd_en_o` is 0 in reset because the FSM is in IDLE.
- `start_i` in cycle 0 gives `busy_o = 1` in cycle 1. The first pop is possible in cycle 1.
- The pop that completes a beat is in cycle N. `m_axis_tvalid` rises in cycle N+1.
- With `tready = 1` and no FIFO gaps, one full beat takes 5 cycles (4 pops + 1 send). Throughput is 0.8 B/cycle.
- `done_o` pulses, and `busy_o` falls, in the cycle after the final handshake.
- `start_i` is accepted in that same cycle.

## Configuration
- `DMA_OUT_PACKER_TKEEP_EN` defined:
  - The `m_axis_tkeep` port exists.
  - Full beats carry `4'b1111`.
  - The final beat carries `(1 << n) - 1`, where `n` is the number of valid bytes (1–4).
- Undefined:
  - There is no `m_axis_tkeep` port.
  - The final partial beat is zero-padded in the unused lanes.
  - The sink derives the valid byte count from the frame length.

## Test plan
- Length 8, FIFO preloaded 0x01..0x08, `tready = 1`: two beats, 0x04030201 then 0x08070605, with `tlast` on beat 2; exactly 8 pops; `done_o` pulses once.
- Length 6, same data: beat 2 is 0x00000605 with `tlast`. With the macro defined, `tkeep` is 4'b1111 then 4'b0011.
- Length 4 with `tready` low for 10 cycles after `tvalid` rises: `tdata` is held at 0x04030201; `tvalid` stays high; `fifo_rd_en_o` stays 0 throughout; one handshake occurs on release.
- Length 5 with `fifo_empty_i` high for 3 cycles between bytes 2 and 3: no pops while empty; beats 0x04030201 and 0x00000005 (`tlast`).
- Length 0 start: `done_o` pulses in cycle 1 with no pops and no `tvalid`. A second `start_i` asserted while busy on a length-8 frame leaves the frame unchanged.
- Reset asserted after 2 pops of a length-8 frame: all outputs are 0 immediately; after release, a new length-4 start produces a correct single beat with `tlast`.
